niosii_system_sysid_regbank: RTL and testbench

NIOSII_SYSTEM_SYSID_REGBANK -- requirements
Module: niosII_system_sysid_regbank

---
 rtl/niosii_system_sysid_regbank.sv | 142 ++++++++++++++
 tb/tb_niosii_system_sysid_regbank.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_system_sysid_regbank.sv
// System ID register bank: read-only ID/timestamp words, a prescaled uptime
// counter with a high-word shadow, a scratch register, control and sticky status.
// Reads come back through a fixed-latency pipeline.
module niosii_system_sysid_regbank #(
  parameter logic [31:0] ID_VALUE      = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter int unsigned PRESCALE      = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam int unsigned CW = COUNTER_WIDTH;
  localparam int unsigned HW = COUNTER_WIDTH - 32;
  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      presc_q, presc_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      scratch_q, scratch_d;
  logic             en_q, en_d;
  logic             lock_q, lock_d;
  logic             ovf_q, ovf_d;

  logic [READ_LATENCY-1:0] vld_q;
  logic [31:0]             dat_q [READ_LATENCY];

  logic        wr_scratch, wr_ctrl, clr, w1c, rd_lo;
  logic        tick, wrap;
  logic [31:0] hi_ext;
  logic [31:0] rdata;

  // Access decode; scratch writes are blocked once the lock bit is set.
  always_comb begin
    wr_scratch = write && (address == 3'd4) && !lock_q;
    wr_ctrl    = write && (address == 3'd5) && byteenable[0];
    clr        = wr_ctrl && writedata[1];
    w1c        = write && (address == 3'd6) && byteenable[0] && writedata[0];
    rd_lo      = read && (address == 3'd2);
  end

  // Uptime prescaler and counter; clear beats a coincident increment.
  always_comb begin
    tick    = en_q && (presc_q == PRESC_MAX);
    wrap    = tick && (&cnt_q) && !clr;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    if (clr) begin
      cnt_d   = '0;
      presc_d = '0;
    end else if (en_q) begin
      if (tick) begin
        presc_d = '0;
        cnt_d   = cnt_q + CW'(1);
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  // Control, scratch, status and shadow next-state.
  always_comb begin
    hi_ext         = '0;
    hi_ext[HW-1:0] = cnt_q[CW-1:32];
    en_d           = wr_ctrl ? writedata[0] : en_q;
    lock_d         = lock_q | (wr_ctrl & writedata[2]);
    shadow_d       = rd_lo ? hi_ext : shadow_q;
    scratch_d      = scratch_q;
    if (wr_scratch) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) scratch_d[8*b +: 8] = writedata[8*b +: 8];
      end
    end
    if (wrap)     ovf_d = 1'b1;
    else if (w1c) ovf_d = 1'b0;
    else          ovf_d = ovf_q;
  end

  // Read mux over the pre-access register values.
  always_comb begin
    rdata = '0;
    case (address)
      3'd0:    rdata = ID_VALUE;
      3'd1:    rdata = TIMESTAMP;
      3'd2:    rdata = cnt_q[31:0];
      3'd3:    rdata = shadow_q;
      3'd4:    rdata = scratch_q;
      3'd5:    rdata = {29'd0, lock_q, 1'b0, en_q};
      3'd6:    rdata = {31'd0, ovf_q};
      default: rdata = '0;
    endcase
  end

  // Register state update with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      presc_q   <= '0;
      shadow_q  <= '0;
      scratch_q <= '0;
      en_q      <= 1'b1;
      lock_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      shadow_q  <= shadow_d;
      scratch_q <= scratch_d;
      en_q      <= en_d;
      lock_q    <= lock_d;
      ovf_q     <= ovf_d;
    end
  end

  // Read return pipeline; idle slots carry zero so readdata is 0 when not valid.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= read;
      dat_q[0] <= read ? rdata : 32'd0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign readdata      = dat_q[READ_LATENCY-1];
  assign readdatavalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_niosii_system_sysid_regbank.sv
// Randomized and directed bench for the sysid register bank with a queue
// scoreboard fed by a behavioural model of the register map.
module tb_niosii_system_sysid_regbank;

  localparam logic [31:0] ID  = 32'h58D0_4A29;
  localparam logic [31:0] TS  = 32'h6523_1A7F;
  localparam int unsigned LAT = 3;
  localparam int unsigned CW  = 40;
  localparam int unsigned PS  = 4;
  localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  niosii_system_sysid_regbank #(
    .ID_VALUE(ID), .TIMESTAMP(TS), .READ_LATENCY(LAT),
    .COUNTER_WIDTH(CW), .PRESCALE(PS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int obs; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  bit mon_on = 0;

  // behavioural model: uptime = base + (enabled clocks since clear) / PS
  logic [63:0] m_base, m_clks;
  logic        m_en, m_lock, m_status;
  logic [31:0] m_scratch, m_shadow;

  function automatic logic [63:0] uptime();
    return (m_base + m_clks / 64'(PS)) & MASK;
  endfunction

  function automatic void model_reset();
    m_base = 0; m_clks = 0; m_en = 1; m_lock = 0; m_status = 0;
    m_scratch = 0; m_shadow = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [63:0] u;
    u = uptime();
    case (a)
      3'd0: return ID;
      3'd1: return TS;
      3'd2: return u[31:0];
      3'd3: return m_shadow;
      3'd4: return m_scratch;
      3'd5: return {29'd0, m_lock, 1'b0, m_en};
      3'd6: return {31'd0, m_status};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_step(input logic rst_v, rd, wr, input logic [2:0] a,
                                     input logic [31:0] wd, input logic [3:0] be, input int e);
    logic        pre_en, pre_lock, clear, wrapped;
    logic [63:0] old;
    exp_t        x;
    if (!rst_v) begin
      while (sb.size() > 0 && sb[sb.size()-1].obs >= e) void'(sb.pop_back());
      model_reset();
      return;
    end
    if (rd) begin
      x.data = model_read(a);
      x.obs  = e + int'(LAT) - 1;
      sb.push_back(x);
    end
    pre_en = m_en; pre_lock = m_lock;
    clear = wr && a == 3'd5 && be[0] && wd[1];
    old = uptime();
    if (clear) begin m_base = 0; m_clks = 0; end
    else if (pre_en) m_clks = m_clks + 1;
    wrapped = !clear && pre_en && old == MASK && uptime() == 0;
    if (wrapped) m_status = 1;
    else if (wr && a == 3'd6 && be[0] && wd[0]) m_status = 0;
    if (wr && a == 3'd5 && be[0]) begin
      m_en = wd[0];
      m_lock = m_lock | wd[2];
    end
    if (wr && a == 3'd4 && !pre_lock)
      for (int b = 0; b < 4; b++) if (be[b]) m_scratch[8*b +: 8] = wd[8*b +: 8];
    if (rd && a == 3'd2) m_shadow = old[63:32];
  endfunction

  task automatic cyc_op(input logic rst_v, rd, wr, input logic [2:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    @(posedge clock); #1;
    reset_n = rst_v; read = rd; write = wr; address = a;
    writedata = wd; byteenable = be;
    model_step(rst_v, rd, wr, a, wd, be, cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_op(1, 0, 0, 3'd0, 32'd0, 4'd0);
  endtask
  task automatic rd_op(input logic [2:0] a);
    cyc_op(1, 1, 0, a, 32'd0, 4'd0);
  endtask
  task automatic wr_op(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
    cyc_op(1, 0, 1, a, wd, be);
  endtask

  // counter must already be disabled so the forced value is stable
  task automatic preload(input logic [63:0] p);
    logic [63:0] pv;
    pv = p;
    idle(1);
    force dut.cnt_q = pv[CW-1:0];
    m_base = pv - m_clks / 64'(PS);
    idle(1);
    release dut.cnt_q;
  endtask

  // scoreboard monitor, samples on the falling edge
  always @(negedge clock) begin
    exp_t e;
    if (mon_on) begin
      if (readdatavalid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid cyc=%0d got data=%h, no read pending", cyc, readdata);
        end else begin
          e = sb.pop_front();
          if (readdata !== e.data || cyc != e.obs) begin
            failures++;
            $display("FAIL read_data got=%h at cyc %0d, expected=%h at cyc %0d",
                     readdata, cyc, e.data, e.obs);
          end
        end
      end else begin
        checks++;
        if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin
          failures++;
          $display("FAIL idle_bus cyc=%0d got valid=%b data=%h, expected valid=0 data=0",
                   cyc, readdatavalid, readdata);
        end
        checks++;
        if (sb.size() > 0 && sb[0].obs <= cyc) begin
          failures++;
          e = sb.pop_front();
          $display("FAIL missing_valid cyc=%0d got no valid, expected data=%h at cyc %0d",
                   cyc, e.data, e.obs);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  a;
    logic [31:0] wd;
    int          found;
    model_reset();
    cyc_op(0, 0, 0, 3'd0, 32'd0, 4'd0);
    cyc_op(0, 0, 0, 3'd0, 32'd0, 4'd0);
    mon_on = 1;
    // first cycle out of reset accepts a read; ID/TS/reserved back-to-back
    rd_op(3'd0); rd_op(3'd1); rd_op(3'd7);
    for (int i = 0; i < 8; i++) rd_op(3'(i));
    idle(4);

    // scratch byte lanes
    wr_op(3'd4, 32'hAABBCCDD, 4'hF);
    wr_op(3'd4, 32'h11223344, 4'b0101);
    wr_op(3'd4, 32'hFFFFFFFF, 4'b0000);
    rd_op(3'd4);
    wr_op(3'd0, 32'h12345678, 4'hF);
    wr_op(3'd7, 32'h12345678, 4'hF);
    rd_op(3'd0); rd_op(3'd7);

    // randomized traffic, lock never set here
    for (int i = 0; i < 600; i++) begin
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd5) begin
        wd[2] = 1'b0;
        wd[0] = ($urandom_range(0, 3) != 0);
        wd[1] = ($urandom_range(0, 7) == 0);
      end
      case ($urandom_range(0, 5))
        0:       idle(1);
        1, 2:    rd_op(a);
        3:       wr_op(a, wd, 4'($urandom));
        4:       cyc_op(1, 1, 1, a, wd, 4'($urandom));
        default: rd_op(3'($urandom_range(2, 3)));
      endcase
    end
    wr_op(3'd5, 32'h1, 4'h1);
    idle(4);

    // shadow of the high word
    wr_op(3'd5, 32'h0, 4'h1);
    preload(64'h1_0000_0004);
    wr_op(3'd5, 32'h1, 4'h1);
    idle(6);
    rd_op(3'd2); rd_op(3'd3);
    idle(40);
    rd_op(3'd3);
    wr_op(3'd5, 32'h0, 4'h1);
    preload(64'h2_0000_0000);
    wr_op(3'd5, 32'h1, 4'h1);
    rd_op(3'd3); rd_op(3'd2); rd_op(3'd3);
    idle(4);

    // wrap with a W1C landing in the wrap cycle
    wr_op(3'd5, 32'h0, 4'h1);
    preload(MASK - 64'd1);
    wr_op(3'd5, 32'h1, 4'h1);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (m_en && uptime() == MASK && ((m_clks + 1) % 64'(PS)) == 0) found = 1;
      else idle(1);
    end
    checks++;
    if (found == 0) begin
      failures++;
      $display("FAIL wrap_setup got no wrap cycle, expected one within 40 cycles");
    end
    wr_op(3'd6, 32'h1, 4'h1);
    rd_op(3'd6); rd_op(3'd2); rd_op(3'd3);
    idle(3);
    wr_op(3'd6, 32'h1, 4'h1);
    rd_op(3'd6);
    idle(4);

    // clear in an increment cycle, then freeze
    idle(5);
    for (int i = 0; i < 8 && ((m_clks + 1) % 64'(PS)) != 0; i++) idle(1);
    wr_op(3'd5, 32'h3, 4'h1);
    rd_op(3'd2); rd_op(3'd5);
    idle(9);
    rd_op(3'd2);
    wr_op(3'd5, 32'h0, 4'h1);
    rd_op(3'd2);
    idle(100);
    rd_op(3'd2);

    // lock blocks scratch writes; CTRL without byteenable[0] ignored
    wr_op(3'd5, 32'h5, 4'h1);
    wr_op(3'd5, 32'h0, 4'hE);
    wr_op(3'd4, 32'h0, 4'hF);
    rd_op(3'd4); rd_op(3'd5);
    idle(4);

    // reset with a read in flight
    rd_op(3'd4);
    cyc_op(0, 0, 0, 3'd0, 32'd0, 4'd0);
    rd_op(3'd5); rd_op(3'd4); rd_op(3'd2);
    idle(10);
    rd_op(3'd2);
    idle(int'(LAT) + 3);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending reads, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
